// File: rtl/dac_playback_pkg.sv
// Shared types and elaboration-time helpers for the sample playback DAC.
package dac_playback_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  function automatic int calc_tick_div(input int clock_freq, input int sample_rate);
    return clock_freq / sample_rate;
  endfunction

  function automatic int midscale(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/dac_playback_fifo.sv
// Power-of-two synchronous FIFO with flush and exact occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [LW-1:0]    r_level;
  logic             w_push, w_pop;

  assign full   = (r_level == LW'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/dac_playback.sv
// Buffered sample playback: FIFO-fed, rate-ticked R2R code plus period-aligned PWM DAC.
module dac_playback
  import dac_playback_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int SAMPLE_RATE = 10_000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [WIDTH-1:0]              R2R_out,
  output logic                          pwm_out,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int TICK_DIV = calc_tick_div(CLOCK_FREQ, SAMPLE_RATE);
  localparam int TW       = $clog2(TICK_DIV);
  localparam int LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WIDTH-1:0] MID       = WIDTH'(midscale(WIDTH));
  localparam logic [WIDTH-1:0] PWM_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0]    HALF      = LW'(FIFO_DEPTH / 2);

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_tick_cnt;
  logic [WIDTH-1:0] r_pwm_cnt, r_duty, r_duty_nxt, r_r2r;
  logic             r_pwm, r_underflow;
  logic             w_full, w_empty, w_tick, w_push, w_pop, w_flush;
  logic [WIDTH-1:0] w_dout;
  logic [LW-1:0]    w_level, w_level_after;

  assign sample_ready  = (r_state != IDLE) && !w_full;
  assign w_push        = sample_valid && sample_ready;
  assign w_tick        = (r_state == PLAY) && (r_tick_cnt == TICK_LAST);
  assign w_pop         = w_tick && !w_empty;
  assign w_flush       = (w_state_nxt == IDLE);
  assign w_level_after = w_level + LW'(w_push) - LW'(w_pop);

  assign R2R_out    = r_r2r;
  assign pwm_out    = r_pwm;
  assign underflow  = r_underflow;
  assign fifo_level = w_level;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (w_flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (sample_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = PRIME;
      PRIME:   if (!enable) w_state_nxt = IDLE;
               else if (w_level_after >= HALF) w_state_nxt = PLAY;
      PLAY:    if (!enable) w_state_nxt = IDLE;
               else if (w_tick && w_empty) w_state_nxt = PRIME;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Preloaded to terminal count so the first PLAY cycle is already a tick.
  always_ff @(posedge clk) begin
    if (!reset)                                       r_tick_cnt <= '0;
    else if (r_state == PRIME && w_state_nxt == PLAY) r_tick_cnt <= TICK_LAST;
    else if (r_state == PLAY)                         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    else                                              r_tick_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_r2r       <= MID;
      r_duty_nxt  <= MID;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_tick && w_empty && enable;
      if (w_flush) begin
        r_r2r      <= MID;
        r_duty_nxt <= MID;
      end else if (w_pop) begin
        r_r2r      <= w_dout;
        r_duty_nxt <= w_dout;
      end
    end
  end

  // Duty only changes at the period wrap, so each period is one clean pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      r_duty    <= MID;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm <= (r_pwm_cnt < r_duty);
      if (r_pwm_cnt == PWM_LAST) begin
        r_pwm_cnt <= '0;
        r_duty    <= r_duty_nxt;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_playback.sv
// Randomized-data bench for dac_playback: scoreboarded R2R stream, tick spacing, PWM duty windows.
module tb_dac_playback;
  logic       clk, reset, enable, sample_valid, sample_ready, pwm_out, underflow;
  logic [7:0] sample_in, R2R_out;
  logic [2:0] fifo_level;

  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, last_chg = 0;
  logic [7:0] expq[$];
  logic       mon_on = 0, chain = 0, prev_uf = 0;
  logic [7:0] prev_r2r = 8'h80, last_v = 8'h80;

  dac_playback #(.WIDTH(8), .CLOCK_FREQ(1000), .SAMPLE_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .R2R_out      (R2R_out),
    .pwm_out      (pwm_out),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_code();
    logic [7:0] v;
    do v = 8'($urandom_range(1, 254)); while (v == 8'h80 || v == 8'h40 || v == last_v);
    return v;
  endfunction

  // Hold the sample until an edge accepts it; the accepted order is the expected playback order.
  task automatic send(input logic [7:0] v);
    int   n;
    logic w;
    n = 0;
    sample_valid = 1;
    sample_in    = v;
    do begin
      w = sample_ready;
      step(1);
      n++;
    end while (!w && n < 100);
    chk("send_acc", w, 1);
    expq.push_back(v);
    last_v = v;
  endtask

  task automatic meas_pwm(input int d);
    int   hi, tr, n;
    logic p;
    hi = 0; tr = 0; n = 0;
    while (cyc % 255 != 1 && n < 300) begin step(1); n++; end
    chk("pwm_align", cyc % 255, 1);
    p = pwm_out;
    for (int i = 0; i < 255; i++) begin
      if (pwm_out) hi++;
      if (pwm_out !== p) tr++;
      p = pwm_out;
      step(1);
    end
    chk("pwm_duty", hi, d);
    chk("pwm_trans", tr, (d == 0 || d == 255) ? 0 : 1);
  endtask

  // PWM counter restarts at reset, so the period phase is the cycle count since reset mod 255.
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mon_on && R2R_out !== prev_r2r) begin
      if (expq.size() > 0) chk("r2r_seq", R2R_out, expq.pop_front());
      else                 chk("r2r_extra", R2R_out, 32'h1FF);
      if (chain) chk("tick_gap", cyc - last_chg, 10);
      chain    <= 1;
      last_chg <= cyc;
    end
    if (underflow) begin
      chk("uf_width", prev_uf, 0);
      chain <= 0;
    end
    if (!mon_on) chain <= 0;
    prev_r2r <= R2R_out;
    prev_uf  <= underflow;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, f;
    int         dv [3];
    dv[0] = 0; dv[1] = 255; dv[2] = 8'h40;

    // Reset with enable and valid asserted.
    reset = 0; enable = 1; sample_valid = 1; sample_in = rnd_code();
    step(3);
    chk("rst_r2r", R2R_out, 8'h80);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_rdy", sample_ready, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_uf", underflow, 0);
    reset = 1;
    #2;
    chk("idle_rdy", sample_ready, 0);
    step(1);
    chk("prime_rdy", sample_ready, 1);
    mon_on = 1;

    // Three-sample prime and playback, then underflow.
    send(sample_in);
    send(rnd_code());
    chk("play_lvl", fifo_level, 2);
    chk("play_r2r0", R2R_out, 8'h80);
    a = rnd_code();
    send(a);
    chk("first_tick_lvl", fifo_level, 2);
    sample_valid = 0;
    step(10);
    chk("lvl_after2", fifo_level, 1);
    step(10);
    chk("lvl_after3", fifo_level, 0);
    chk("r2r_third", R2R_out, a);
    step(10);
    chk("uf_pulse", underflow, 1);
    chk("uf_hold", R2R_out, a);
    step(1);
    chk("uf_clear", underflow, 0);
    chk("uf_rdy", sample_ready, 1);

    // Resume from PRIME with two samples; third tick underflows.
    a = rnd_code(); send(a);
    b = rnd_code(); send(b);
    sample_valid = 0;
    step(1);
    chk("resume_a", R2R_out, a);
    step(10);
    chk("resume_b", R2R_out, b);
    step(10);
    chk("uf2_pulse", underflow, 1);
    chk("uf2_hold", R2R_out, b);

    // PWM duty windows; last code is held in PRIME after underflow.
    for (int k = 0; k < 3; k++) begin
      f = rnd_code(); send(f);
      send(8'(dv[k]));
      sample_valid = 0;
      step(11);
      chk("pwm_code", R2R_out, dv[k]);
      step(255);
      meas_pwm(dv[k]);
    end

    // Back-pressure with six queued samples.
    for (int k = 0; k < 5; k++) send(rnd_code());
    chk("full_lvl", fifo_level, 4);
    chk("full_rdy", sample_ready, 0);
    send(rnd_code());
    chk("refill_lvl", fifo_level, 4);
    sample_valid = 0;
    step(50);
    chk("drain_sb", expq.size(), 0);
    chk("drain_lvl", fifo_level, 0);

    // Disable mid-PLAY with three queued.
    for (int k = 0; k < 4; k++) send(rnd_code());
    chk("dis_lvl3", fifo_level, 3);
    enable = 0; sample_valid = 0; mon_on = 0;
    step(1);
    chk("dis_lvl", fifo_level, 0);
    chk("dis_r2r", R2R_out, 8'h80);
    chk("dis_rdy", sample_ready, 0);
    expq.delete();
    enable = 1;
    step(1);
    chk("reen_rdy", sample_ready, 1);
    mon_on = 1;

    // Reset mid-PLAY: no underflow while held.
    for (int k = 0; k < 3; k++) send(rnd_code());
    chk("rst_play_lvl", fifo_level, 2);
    mon_on = 0; sample_valid = 0; reset = 0;
    step(1);
    chk("mrst_lvl", fifo_level, 0);
    chk("mrst_r2r", R2R_out, 8'h80);
    chk("mrst_rdy", sample_ready, 0);
    chk("mrst_pwm", pwm_out, 0);
    for (int k = 0; k < 12; k++) begin
      chk("mrst_uf", underflow, 0);
      step(1);
    end
    expq.delete();
    reset = 1;
    step(1);
    chk("post_rst_rdy", sample_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
